hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 15 +
 rtl/hazard_ctrl_md_busy_ctr.sv | 36 +++
 rtl/hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_hazard_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared constants and types for the pipeline hazard controller
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam int MD_CNT_W = 4;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } memState_t;

endpackage

// File: rtl/hazard_ctrl_md_busy_ctr.sv
// rtl/hazard_ctrl_md_busy_ctr.sv - mul/div occupancy down-counter with registered busy flag
module md_busy_ctr
    import hazard_ctrl_pkg::*;
#(
    parameter int MD_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic busy
);

    logic [MD_CNT_W-1:0] count;
    logic [MD_CNT_W-1:0] countNext;

    // A fresh load always wins, even over a count still in flight.
    always_comb begin
        countNext = count;
        if (load) begin
            countNext = MD_CNT_W'(MD_LAT);
        end else if (count != '0) begin
            countNext = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            busy  <= 1'b0;
        end else begin
            count <= countNext;
            busy  <= (countNext != '0);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard detection, forwarding select and stall statistics
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch_d,
    input  logic              mem_to_reg_e,
    input  logic              mem_to_reg_m,
    input  logic              reg_w_e,
    input  logic              reg_w_m,
    input  logic              reg_w_w,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    input  logic [REG_AW-1:0] rs_e,
    input  logic [REG_AW-1:0] rt_e,
    input  logic [REG_AW-1:0] write_reg_e,
    input  logic [REG_AW-1:0] write_reg_m,
    input  logic [REG_AW-1:0] write_reg_w,
    input  logic              mem_req_m,
    input  logic              mem_ready,
    input  logic              md_start_e,
    input  logic              md_use_d,
    input  logic              clr_cnt,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              flush_e,
    output logic              flush_w,
    output logic              fwd_a_d,
    output logic              fwd_b_d,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic              md_busy,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic      lwStall;
    logic      brStall;
    logic      memStall;
    logic      mdStall;
    memState_t memState;
    memState_t memStateNext;

    function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] src);
        if (src != '0 && src == write_reg_m && reg_w_m) begin
            return FWD_M;
        end else if (src != '0 && src == write_reg_w && reg_w_w) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

    function automatic logic brMatch(input logic [REG_AW-1:0] src);
        return (src != '0) &&
               ((reg_w_e && src == write_reg_e) || (mem_to_reg_m && src == write_reg_m));
    endfunction

    assign fwd_a_e = fwdSel(rs_e);
    assign fwd_b_e = fwdSel(rt_e);
    assign fwd_a_d = (rs_d != '0) && (rs_d == write_reg_m) && reg_w_m;
    assign fwd_b_d = (rt_d != '0) && (rt_d == write_reg_m) && reg_w_m;

    assign lwStall  = mem_to_reg_e && (rt_e != '0) && ((rs_d == rt_e) || (rt_d == rt_e));
    assign brStall  = branch_d && (brMatch(rs_d) || brMatch(rt_d));
    assign memStall = mem_req_m && !mem_ready;
    assign mdStall  = md_use_d && md_busy;

    // A memory wait freezes the whole front of the pipe and bubbles W;
    // decode hazards only hold F/D and bubble E.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (memStall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (lwStall || brStall || mdStall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    md_busy_ctr #(
        .MD_LAT (MD_LAT)
    ) u_md_busy_ctr (
        .clk  (clk),
        .rst  (rst),
        .load (md_start_e && !memStall),
        .busy (md_busy)
    );

    always_comb begin
        memStateNext = memState;
        case (memState)
            MEM_IDLE: if (memStall)               memStateNext = MEM_WAIT;
            MEM_WAIT: if (mem_ready || !mem_req_m) memStateNext = MEM_IDLE;
            default:                              memStateNext = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            memState <= MEM_IDLE;
        end else begin
            memState <= memStateNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            stall_cnt <= '0;
        end else if (stall_f && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int REG_AW = 5;
    localparam int MD_LAT = 4;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              branch_d, mem_to_reg_e, mem_to_reg_m, reg_w_e, reg_w_m, reg_w_w;
    logic [REG_AW-1:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
    logic              mem_req_m, mem_ready, md_start_e, md_use_d, clr_cnt;
    logic              stall_f, stall_d, stall_e, stall_m, flush_e, flush_w;
    logic              fwd_a_d, fwd_b_d, md_busy;
    logic [1:0]        fwd_a_e, fwd_b_e;
    logic [CNT_W-1:0]  stall_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .REG_AW (REG_AW),
        .MD_LAT (MD_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .branch_d     (branch_d),
        .mem_to_reg_e (mem_to_reg_e),
        .mem_to_reg_m (mem_to_reg_m),
        .reg_w_e      (reg_w_e),
        .reg_w_m      (reg_w_m),
        .reg_w_w      (reg_w_w),
        .rs_d         (rs_d),
        .rt_d         (rt_d),
        .rs_e         (rs_e),
        .rt_e         (rt_e),
        .write_reg_e  (write_reg_e),
        .write_reg_m  (write_reg_m),
        .write_reg_w  (write_reg_w),
        .mem_req_m    (mem_req_m),
        .mem_ready    (mem_ready),
        .md_start_e   (md_start_e),
        .md_use_d     (md_use_d),
        .clr_cnt      (clr_cnt),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .stall_e      (stall_e),
        .stall_m      (stall_m),
        .flush_e      (flush_e),
        .flush_w      (flush_w),
        .fwd_a_d      (fwd_a_d),
        .fwd_b_d      (fwd_b_d),
        .fwd_a_e      (fwd_a_e),
        .fwd_b_e      (fwd_b_e),
        .md_busy      (md_busy),
        .stall_cnt    (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Stall/flush vector packed as {f,d,e,m,flush_e,flush_w}.
    task automatic chkStall(input string tag, input logic [5:0] exp);
        chk(tag, {26'd0, stall_f, stall_d, stall_e, stall_m, flush_e, flush_w}, {26'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        branch_d = 0; mem_to_reg_e = 0; mem_to_reg_m = 0;
        reg_w_e = 0; reg_w_m = 0; reg_w_w = 0;
        rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
        write_reg_e = 0; write_reg_m = 0; write_reg_w = 0;
        mem_req_m = 0; mem_ready = 0; md_start_e = 0; md_use_d = 0; clr_cnt = 0;
    endtask

    task automatic setLw();
        mem_to_reg_e = 1; rt_e = 7; rs_d = 7;
    endtask

    task automatic clearCnt();
        clr_cnt = 1; tick(); clr_cnt = 0;
    endtask

    initial begin
        idleInputs();
        rst = 1;
        @(negedge clk);
        tick(); tick();
        rst = 0;
        #1;
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_md_busy", 32'(md_busy), 32'd0);
        chk("rst_fsm", 32'(dut.memState), 32'(MEM_IDLE));
        chkStall("rst_stalls", 6'b000000);
        chk("rst_fwd_a_e", 32'(fwd_a_e), 32'(FWD_RF));

        // Forwarding
        rs_e = 3; write_reg_m = 3; reg_w_m = 1; write_reg_w = 3; reg_w_w = 1; #1;
        chk("fwd_a_e_m_prio", 32'(fwd_a_e), 32'b10);
        rs_e = 0; #1;
        chk("fwd_a_e_zero", 32'(fwd_a_e), 32'b00);
        rs_e = 3; reg_w_m = 0; #1;
        chk("fwd_a_e_w", 32'(fwd_a_e), 32'b01);
        rt_e = 5; write_reg_w = 5; #1;
        chk("fwd_b_e_w", 32'(fwd_b_e), 32'b01);
        chk("fwd_a_e_none", 32'(fwd_a_e), 32'b00);
        rs_d = 3; rt_d = 4; reg_w_m = 1; #1;
        chk("fwd_a_d", 32'(fwd_a_d), 32'd1);
        chk("fwd_b_d", 32'(fwd_b_d), 32'd0);
        idleInputs();

        // Load-use stall, one cycle
        clearCnt();
        setLw(); #1;
        chkStall("lw_stall", 6'b110010);
        tick();
        idleInputs(); #1;
        chkStall("lw_released", 6'b000000);
        chk("lw_stall_cnt", 32'(stall_cnt), 32'd1);

        // Branch hazards
        branch_d = 1; rs_d = 4; write_reg_e = 4; reg_w_e = 1; #1;
        chkStall("br_e", 6'b110010);
        rs_d = 0; write_reg_e = 0; rt_d = 6; write_reg_m = 6; mem_to_reg_m = 1; #1;
        chkStall("br_m_load", 6'b110010);
        rt_d = 0; write_reg_m = 0; #1;
        chkStall("br_zero_reg", 6'b000000);
        idleInputs();

        // Memory wait overriding a load-use stall
        clearCnt();
        mem_req_m = 1; mem_ready = 0; setLw();
        for (int i = 0; i < 3; i++) begin
            #1;
            chkStall("mem_stall", 6'b111101);
            tick();
            chk("mem_fsm_wait", 32'(dut.memState), 32'(MEM_WAIT));
        end
        chk("mem_stall_cnt", 32'(stall_cnt), 32'd3);
        mem_ready = 1; #1;
        chkStall("mem_ready_lw", 6'b110010);
        tick();
        chk("mem_fsm_idle", 32'(dut.memState), 32'(MEM_IDLE));
        chk("mem_stall_cnt2", 32'(stall_cnt), 32'd4);
        idleInputs();

        // Mul/div occupancy
        md_start_e = 1; tick();
        md_start_e = 0; md_use_d = 1;
        for (int i = 0; i < MD_LAT; i++) begin
            #1;
            chk("md_busy_hi", 32'(md_busy), 32'd1);
            chk("md_stall_d", 32'(stall_d), 32'd1);
            tick();
        end
        chk("md_busy_lo", 32'(md_busy), 32'd0);
        chk("md_stall_d_lo", 32'(stall_d), 32'd0);
        idleInputs();

        // Load suppressed by memory wait
        md_start_e = 1; mem_req_m = 1; tick();
        chk("md_no_load_memstall", 32'(md_busy), 32'd0);
        idleInputs();

        // Reset mid mul/div
        clearCnt();
        setLw(); md_start_e = 1; tick();
        md_start_e = 0; tick();
        chk("mid_md_busy", 32'(md_busy), 32'd1);
        chk("mid_md_cnt", 32'(stall_cnt), 32'd2);
        rst = 1; #1;
        chk("rst_comb_follows", 32'(stall_f), 32'd1);
        tick();
        rst = 0;
        chk("rst_md_busy_drop", 32'(md_busy), 32'd0);
        chk("rst_cnt_drop", 32'(stall_cnt), 32'd0);
        idleInputs();

        // Saturation and clear priority
        setLw();
        for (int i = 0; i < 20; i++) tick();
        chk("sat_cnt", 32'(stall_cnt), 32'd15);
        clr_cnt = 1; tick();
        chk("clr_wins", 32'(stall_cnt), 32'd0);
        idleInputs();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
